// File: rtl/rf_write_sched.sv
// Write-back scheduler: buffers ALU, load and MDU register writes and packs them
// onto the two general register-file write ports plus the dedicated R15 port.
module rf_write_sched #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [3:0]        alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [3:0]        mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [3:0]        mdu_dest,
    input  logic [DATA_W-1:0] mdu_lo,
    input  logic [DATA_W-1:0] mdu_hi,
    output logic [2:0]        regWrite,
    output logic [3:0]        wr,
    output logic [3:0]        wr2,
    output logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] wd2,
    output logic [DATA_W-1:0] wd15,
    output logic [NREG-1:0]   pend_mask
);
    localparam int         NSRC = 3;
    localparam logic [3:0] R15  = 4'd15;
    localparam logic [1:0] SRC_C = 2'd2;

    // Requester index 0 = ALU (A), 1 = load unit (B), 2 = MDU (C).
    logic [NSRC-1:0]   in_valid;
    logic [3:0]        in_dest [NSRC];
    logic [DATA_W-1:0] in_data [NSRC];

    logic [NSRC-1:0]   h_valid_reg;
    logic [3:0]        h_dest_reg [NSRC];
    logic [DATA_W-1:0] h_data_reg [NSRC];
    logic [DATA_W-1:0] h_hi_reg;
    logic [1:0]        rr_reg;
    logic [1:0]        rr_next;

    logic [NSRC-1:0]   grant;
    logic [NSRC-1:0]   ready;

    logic              p1_en, p2_en, r15_en;
    logic [3:0]        p1_addr, p2_addr;
    logic [DATA_W-1:0] p1_data, p2_data;

    assign in_valid   = {mdu_valid, mem_valid, alu_valid};
    assign in_dest[0] = alu_dest;
    assign in_dest[1] = mem_dest;
    assign in_dest[2] = mdu_dest;
    assign in_data[0] = alu_data;
    assign in_data[1] = mem_data;
    assign in_data[2] = mdu_lo;

    assign alu_ready = ready[0];
    assign mem_ready = ready[1];
    assign mdu_ready = ready[2];

    // A slot is free when empty or when its current content issues this cycle.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_hold
            assign ready[gi] = ~h_valid_reg[gi] | grant[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    h_valid_reg[gi] <= 1'b0;
                end else if (in_valid[gi] && ready[gi]) begin
                    h_valid_reg[gi] <= 1'b1;
                    h_dest_reg[gi]  <= in_dest[gi];
                    h_data_reg[gi]  <= in_data[gi];
                end else if (grant[gi]) begin
                    h_valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (mdu_valid && ready[2]) begin
            h_hi_reg <= mdu_hi;
        end
    end

    // Round-robin scan. 'taken' holds every register already written this cycle;
    // a granted MDU marks R15 as well, which covers both R15 conflict rules.
    always_comb begin
        logic [NREG-1:0] taken;
        logic [2:0]      pos;
        logic [1:0]      idx;
        logic [1:0]      nsel;
        logic            elig;
        taken   = '0;
        pos     = 3'd0;
        idx     = 2'd0;
        nsel    = 2'd0;
        elig    = 1'b0;
        grant   = '0;
        rr_next = rr_reg;
        p1_en   = 1'b0;
        p2_en   = 1'b0;
        r15_en  = 1'b0;
        p1_addr = '0;
        p2_addr = '0;
        p1_data = '0;
        p2_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            pos = {1'b0, rr_reg} + 3'(k);
            if (pos >= 3'(NSRC)) begin
                pos = pos - 3'(NSRC);
            end
            idx  = pos[1:0];
            elig = h_valid_reg[idx] && (nsel < 2'd2) && !taken[h_dest_reg[idx]];
            if (idx == SRC_C && taken[15]) begin
                elig = 1'b0;
            end
            if (elig) begin
                grant[idx]               = 1'b1;
                rr_next                  = (idx == SRC_C) ? 2'd0 : idx + 2'd1;
                taken[h_dest_reg[idx]]   = 1'b1;
                if (idx == SRC_C) begin
                    taken[15] = 1'b1;
                    r15_en    = 1'b1;
                end
                // An MDU write to R15 itself needs only the R15 port; lo is dropped.
                if (!(idx == SRC_C && h_dest_reg[idx] == R15)) begin
                    if (nsel == 2'd0) begin
                        p1_en   = 1'b1;
                        p1_addr = h_dest_reg[idx];
                        p1_data = h_data_reg[idx];
                    end else begin
                        p2_en   = 1'b1;
                        p2_addr = h_dest_reg[idx];
                        p2_data = h_data_reg[idx];
                    end
                end
                nsel = nsel + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_reg   <= 2'd0;
            regWrite <= 3'b000;
            wr       <= '0;
            wr2      <= '0;
            wd       <= '0;
            wd2      <= '0;
            wd15     <= '0;
        end else begin
            rr_reg   <= rr_next;
            regWrite <= {r15_en, p2_en, p1_en};
            if (p1_en) begin
                wr <= p1_addr;
                wd <= p1_data;
            end
            if (p2_en) begin
                wr2 <= p2_addr;
                wd2 <= p2_data;
            end
            if (r15_en) begin
                wd15 <= h_hi_reg;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (h_valid_reg[i]) begin
                pend_mask[h_dest_reg[i]] = 1'b1;
            end
        end
        if (h_valid_reg[2]) begin
            pend_mask[15] = 1'b1;
        end
        if (regWrite[0]) begin
            pend_mask[wr] = 1'b1;
        end
        if (regWrite[1]) begin
            pend_mask[wr2] = 1'b1;
        end
        if (regWrite[2]) begin
            pend_mask[15] = 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_write_sched.sv
// Bench for rf_write_sched: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a set-based reference model.
module tb_rf_write_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, mdu_valid;
    logic        alu_ready, mem_ready, mdu_ready;
    logic [3:0]  alu_dest, mem_dest, mdu_dest;
    logic [15:0] alu_data, mem_data, mdu_lo, mdu_hi;
    logic [2:0]  regWrite;
    logic [3:0]  wr, wr2;
    logic [15:0] wd, wd2, wd15;
    logic [15:0] pend_mask;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] rf [16];

    rf_write_sched dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_dest(mdu_dest),
        .mdu_lo(mdu_lo), .mdu_hi(mdu_hi),
        .regWrite(regWrite), .wr(wr), .wr2(wr2), .wd(wd), .wd2(wd2), .wd15(wd15),
        .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    // Register file image, capturing whatever the scheduler presents.
    always @(posedge clk) begin
        if (regWrite[0]) rf[wr] <= wd;
        if (regWrite[1]) rf[wr2] <= wd2;
        if (regWrite[2]) rf[15] <= wd15;
    end

    typedef struct {
        logic        av; logic [3:0] ad; logic [15:0] adat;
        logic        bv; logic [3:0] bd; logic [15:0] bdat;
        logic        cv; logic [3:0] cd; logic [15:0] clo; logic [15:0] chi;
        logic [2:0]  rw; logic [3:0] ewr; logic [15:0] ewd;
        logic [3:0]  ewr2; logic [15:0] ewd2; logic [15:0] ewd15;
    } vec_t;

    typedef struct {
        logic v; logic [3:0] d; logic [15:0] lo; logic [15:0] hi;
    } hreq_t;

    // Reference model state.
    hreq_t       mh [3];
    int          mrr;
    logic [2:0]  m_rw;
    logic [3:0]  m_wr, m_wr2;
    logic [15:0] m_wd, m_wd2, m_wd15;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] bundle(input logic [2:0] r, input logic [3:0] a1,
                                           input logic [15:0] d1, input logic [3:0] a2,
                                           input logic [15:0] d2, input logic [15:0] d15);
        return {5'b0, r, a1, d1, a2, d2, d15};
    endfunction

    function automatic logic [63:0] dut_out();
        return bundle(regWrite, wr, wd, wr2, wd2, wd15);
    endfunction

    task automatic idle;
        alu_valid = 1'b0; mem_valid = 1'b0; mdu_valid = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input logic av, input logic [3:0] ad, input logic [15:0] adat,
                         input logic bv, input logic [3:0] bd, input logic [15:0] bdat,
                         input logic cv, input logic [3:0] cd, input logic [15:0] clo,
                         input logic [15:0] chi);
        alu_valid = av; alu_dest = ad; alu_data = adat;
        mem_valid = bv; mem_dest = bd; mem_data = bdat;
        mdu_valid = cv; mdu_dest = cd; mdu_lo = clo; mdu_hi = chi;
    endtask

    function automatic logic [3:0] rnd_dest();
        if ($urandom_range(0, 4) == 0) return 4'd15;
        return 4'($urandom_range(1, 4));
    endfunction

    // Each grant claims the set of registers it writes; a clash with anything
    // already claimed this cycle means the requester waits.
    task automatic model_grant(output logic [2:0] g, output logic [2:0] en,
                               output logic [3:0] a1, output logic [3:0] a2,
                               output logic [15:0] d1, output logic [15:0] d2,
                               output logic [15:0] d15, output int nrr);
        int written[$];
        int slot;
        g = '0; en = '0; a1 = '0; a2 = '0; d1 = '0; d2 = '0; d15 = '0;
        nrr = mrr; slot = 0;
        for (int k = 0; k < 3; k++) begin
            int i;
            int want[$];
            bit clash;
            i = (mrr + k) % 3;
            clash = 1'b0;
            if (mh[i].v && slot < 2) begin
                want.push_back(int'(mh[i].d));
                if (i == 2) want.push_back(15);
                foreach (want[w]) foreach (written[t]) if (want[w] == written[t]) clash = 1'b1;
                if (!clash) begin
                    foreach (want[w]) written.push_back(want[w]);
                    g[i] = 1'b1;
                    nrr = (i + 1) % 3;
                    if (i == 2) begin
                        en[2] = 1'b1;
                        d15 = mh[2].hi;
                    end
                    if (!(i == 2 && mh[i].d == 4'd15)) begin
                        if (slot == 0) begin
                            en[0] = 1'b1; a1 = mh[i].d; d1 = mh[i].lo;
                        end else begin
                            en[1] = 1'b1; a2 = mh[i].d; d2 = mh[i].lo;
                        end
                    end
                    slot++;
                end
            end
        end
    endtask

    task automatic model_reset;
        for (int i = 0; i < 3; i++) mh[i] = '{1'b0, 4'd0, 16'h0, 16'h0};
        mrr = 0; m_rw = 3'b000; m_wr = 4'd0; m_wr2 = 4'd0;
        m_wd = 16'h0; m_wd2 = 16'h0; m_wd15 = 16'h0;
    endtask

    vec_t vecs [10];

    initial begin
        logic [2:0]  g, en, exp_rdy, in_v;
        logic [3:0]  a1, a2;
        logic [15:0] d1, d2, d15, exp_pend;
        int          nrr;
        hreq_t       in_req [3];

        reset = 1'b0;
        idle();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 16'h0);

        vecs[0] = '{1'b1, 4'd1, 16'hAAAA, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 16'h0,
                    3'b001, 4'd1, 16'hAAAA, 4'd0, 16'h0, 16'h0};
        vecs[1] = '{1'b1, 4'd2, 16'h1111, 1'b1, 4'd3, 16'h2222, 1'b0, 4'd0, 16'h0, 16'h0,
                    3'b011, 4'd2, 16'h1111, 4'd3, 16'h2222, 16'h0};
        vecs[2] = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd15, 16'h1234, 16'hABCD,
                    3'b100, 4'd0, 16'h0, 4'd0, 16'h0, 16'hABCD};
        vecs[3] = '{1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'hBBBB, 1'b0, 4'd0, 16'h0, 16'h0,
                    3'b001, 4'd5, 16'hAAAA, 4'd0, 16'h0, 16'h0};
        vecs[4] = '{1'b1, 4'd15, 16'h5555, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 16'h0123, 16'hABCD,
                    3'b001, 4'd15, 16'h5555, 4'd0, 16'h0, 16'h0};
        vecs[5] = '{1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'h7777, 1'b1, 4'd8, 16'h0888, 16'h8888,
                    3'b111, 4'd7, 16'h7777, 4'd8, 16'h0888, 16'h8888};
        vecs[6] = '{1'b1, 4'd1, 16'h0001, 1'b1, 4'd2, 16'h0002, 1'b1, 4'd3, 16'h0003, 16'h0033,
                    3'b011, 4'd1, 16'h0001, 4'd2, 16'h0002, 16'h0};
        vecs[7] = '{1'b0, 4'd0, 16'h0, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd15, 16'h1515, 16'hF00F,
                    3'b101, 4'd6, 16'h6666, 4'd0, 16'h0, 16'hF00F};
        vecs[8] = '{1'b1, 4'd15, 16'hAAAA, 1'b1, 4'd15, 16'hBBBB, 1'b0, 4'd0, 16'h0, 16'h0,
                    3'b001, 4'd15, 16'hAAAA, 4'd0, 16'h0, 16'h0};
        vecs[9] = '{1'b1, 4'd3, 16'h3333, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h0303, 16'h3030,
                    3'b001, 4'd3, 16'h3333, 4'd0, 16'h0, 16'h0};

        // Reset state.
        do_reset();
        check("reset_out", dut_out(), bundle(3'b000, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0));
        check("reset_pend", 64'(pend_mask), 64'h0);
        check("reset_ready", 64'({alu_ready, mem_ready, mdu_ready}), 64'(3'b111));

        // Table vectors, each from reset (rr = A).
        foreach (vecs[v]) begin
            do_reset();
            drive(vecs[v].av, vecs[v].ad, vecs[v].adat, vecs[v].bv, vecs[v].bd, vecs[v].bdat,
                  vecs[v].cv, vecs[v].cd, vecs[v].clo, vecs[v].chi);
            tick();
            idle();
            tick();
            $display("vec %0d: regWrite=%b wr=%h wd=%h wr2=%h wd2=%h wd15=%h",
                     v, regWrite, wr, wd, wr2, wd2, wd15);
            check($sformatf("vec%0d", v), dut_out(),
                  bundle(vecs[v].rw, vecs[v].ewr, vecs[v].ewd, vecs[v].ewr2, vecs[v].ewd2,
                         vecs[v].ewd15));
        end

        // Single request: pend bit 1 for two cycles, then idle.
        do_reset();
        drive(1'b1, 4'd1, 16'hAAAA, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 16'h0);
        tick();
        idle();
        check("single_pend0", 64'(pend_mask), 64'h0002);
        tick();
        check("single_out", dut_out(), bundle(3'b001, 4'd1, 16'hAAAA, 4'd0, 16'h0, 16'h0));
        check("single_pend1", 64'(pend_mask), 64'h0002);
        tick();
        check("single_done", 64'(regWrite), 64'(3'b000));
        check("single_pend2", 64'(pend_mask), 64'h0000);
        $display("seq single: regWrite=%b pend=%h", regWrite, pend_mask);

        // Destination collision: second write waits one cycle, R5 ends at BBBB.
        do_reset();
        drive(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'hBBBB, 1'b0, 4'd0, 16'h0, 16'h0);
        tick();
        idle();
        check("coll_ready", 64'({alu_ready, mem_ready, mdu_ready}), 64'(3'b101));
        tick();
        check("coll_c1", dut_out(), bundle(3'b001, 4'd5, 16'hAAAA, 4'd0, 16'h0, 16'h0));
        tick();
        check("coll_c2", dut_out(), bundle(3'b001, 4'd5, 16'hBBBB, 4'd0, 16'h0, 16'h0));
        tick();
        check("coll_rf5", 64'(rf[5]), 64'hBBBB);
        check("coll_idle", 64'(regWrite), 64'(3'b000));
        $display("seq collision: rf5=%h", rf[5]);

        // MDU with R15 conflict, scan starting at C.
        do_reset();
        drive(1'b1, 4'd2, 16'h1111, 1'b1, 4'd3, 16'h2222, 1'b0, 4'd0, 16'h0, 16'h0);
        tick();
        idle();
        tick();
        drive(1'b1, 4'd15, 16'h5555, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 16'h0123, 16'hABCD);
        tick();
        idle();
        tick();
        check("r15c_c1", dut_out(), bundle(3'b101, 4'd4, 16'h0123, 4'd3, 16'h2222, 16'hABCD));
        tick();
        check("r15c_c2", dut_out(), bundle(3'b001, 4'd15, 16'h5555, 4'd3, 16'h2222, 16'hABCD));
        $display("seq r15 conflict: regWrite=%b wr=%h wd=%h", regWrite, wr, wd);

        // Three-way contention: third issues one cycle later.
        do_reset();
        drive(1'b1, 4'd1, 16'h0001, 1'b1, 4'd2, 16'h0002, 1'b1, 4'd3, 16'h0003, 16'h0033);
        tick();
        idle();
        tick();
        check("three_c1", dut_out(), bundle(3'b011, 4'd1, 16'h0001, 4'd2, 16'h0002, 16'h0));
        tick();
        check("three_c2", dut_out(), bundle(3'b101, 4'd3, 16'h0003, 4'd2, 16'h0002, 16'h0033));
        $display("seq three-way: regWrite=%b wr=%h wd15=%h", regWrite, wr, wd15);

        // Reset in mid-operation with all requesters busy on one destination.
        do_reset();
        drive(1'b1, 4'd5, 16'h1001, 1'b1, 4'd5, 16'h2002, 1'b1, 4'd5, 16'h3003, 16'h4004);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("midrst_out", dut_out(), bundle(3'b000, 4'd0, 16'h0, 4'd0, 16'h0, 16'h0));
        check("midrst_pend", 64'(pend_mask), 64'h0);
        check("midrst_ready", 64'({alu_ready, mem_ready, mdu_ready}), 64'(3'b111));
        repeat (3) tick();
        check("midrst_stale", 64'({regWrite, pend_mask}), 64'h0);
        $display("seq mid reset: regWrite=%b pend=%h", regWrite, pend_mask);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 99) == 0);
            alu_valid = ($urandom_range(0, 2) != 0);
            mem_valid = ($urandom_range(0, 2) != 0);
            mdu_valid = ($urandom_range(0, 3) == 0);
            alu_dest = rnd_dest(); alu_data = 16'($urandom);
            mem_dest = rnd_dest(); mem_data = 16'($urandom);
            mdu_dest = rnd_dest(); mdu_lo = 16'($urandom); mdu_hi = 16'($urandom);
            in_v = {mdu_valid, mem_valid, alu_valid};
            in_req[0] = '{1'b1, alu_dest, alu_data, 16'h0};
            in_req[1] = '{1'b1, mem_dest, mem_data, 16'h0};
            in_req[2] = '{1'b1, mdu_dest, mdu_lo, mdu_hi};

            model_grant(g, en, a1, a2, d1, d2, d15, nrr);
            exp_pend = 16'h0;
            for (int i = 0; i < 3; i++) begin
                exp_rdy[i] = !mh[i].v || g[i];
                if (mh[i].v) begin
                    exp_pend[mh[i].d] = 1'b1;
                    if (i == 2) exp_pend[15] = 1'b1;
                end
            end
            if (m_rw[0]) exp_pend[m_wr] = 1'b1;
            if (m_rw[1]) exp_pend[m_wr2] = 1'b1;
            if (m_rw[2]) exp_pend[15] = 1'b1;
            check("rnd_ready", 64'({mdu_ready, mem_ready, alu_ready}), 64'(exp_rdy));
            check("rnd_pend", 64'(pend_mask), 64'(exp_pend));

            if (reset) begin
                model_reset();
            end else begin
                m_rw = en;
                if (en[0]) begin m_wr = a1; m_wd = d1; end
                if (en[1]) begin m_wr2 = a2; m_wd2 = d2; end
                if (en[2]) m_wd15 = d15;
                for (int i = 0; i < 3; i++) begin
                    if (in_v[i] && exp_rdy[i]) mh[i] = in_req[i];
                    else if (g[i]) mh[i].v = 1'b0;
                end
                mrr = nrr;
            end
            tick();
            check("rnd_out", dut_out(), bundle(m_rw, m_wr, m_wd, m_wr2, m_wd2, m_wd15));
        end
        reset = 1'b0;
        idle();
        $display("random phase: 3000 cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Write-back scheduler for the 16 x 16-bit register file. It accepts register write requests from three producers (ALU, memory load unit, multiply/divide unit) and buffers each in a one-deep holding register. Every cycle it packs pending writes onto the register file's two general write ports and the dedicated R15 port. It drives `regWrite`, `wr`, `wd`, `wr2`, `wd2` and `wd15` directly, and exports a pending-write mask for hazard detection.

## Interface
- `DATA_W`, default 16: register data width.
- `NREG`, default 16: register count. Fixed at 16; the address is 4 bits.
- `clk`  in  1  the one clock.
- `reset`  in  1  synchronous, active-high reset.
- `alu_valid` / `alu_ready`  in / out  1  ALU request handshake.
- `alu_dest`, `alu_data`  in  4, 16  ALU destination register and write data.
- `mem_valid` / `mem_ready`  in / out  1  load unit request handshake.
- `mem_dest`, `mem_data`  in  4, 16  load destination register and write data.
- `mdu_valid` / `mdu_ready`  in / out  1  MDU request handshake.
- `mdu_dest`, `mdu_lo`, `mdu_hi`  in  4, 16, 16  MDU destination register, low result, and high result (the high result is written to R15).
- `regWrite`  out  3  bit0 enables port 1 (`wr`/`wd`), bit1 enables port 2 (`wr2`/`wd2`), bit2 enables the R15 write (`wd15`).
- `wr`, `wr2`  out  4  port 1 and port 2 destination addresses.
- `wd`, `wd2`, `wd15`  out  16  port 1, port 2 and R15 write data.
- `pend_mask`  out  16  bit n is set when a write to Rn is buffered or is being issued.

## Operation
- **Holding registers.** There are three: H_A (ALU), H_B (mem) and H_C (MDU). Each has a valid flag, a destination and data (H_C holds both lo and hi).
- **Acceptance.** A request is accepted on a clock edge where valid and ready are both high.
- **Ready.** `x_ready = ~H_x.valid | grant_x`. The ready path depends on the grant logic only, never on the same requester's `x_valid`.
- **Grant scan.** The scan is combinational over the valid holding registers. It starts at the round-robin pointer `rr` (A, B or C) and runs in circular order.
  - The first eligible requester gets port 1; the second gets port 2. At most two are granted.
- **Eligibility: duplicate destination.** A requester is skipped if its destination equals a destination already granted this cycle.
- **Eligibility: R15 conflicts.**
  - A request with dest 15 is skipped if H_C is granted this cycle, because R15 is then already written via `wd15`.
  - H_C is skipped if a request with dest 15 was granted earlier in the scan.
- **MDU issue is atomic.** When H_C is granted, it takes one general port (`mdu_lo` to `mdu_dest`) and sets `regWrite[2]` with `wd15 = mdu_hi` in the same issue.
  - If `mdu_dest == 15`, no general port is used and only `wd15 = mdu_hi` is written. The lo result is dropped.
- **Pointer update.** If any grant occurs, `rr` moves to the requester after the last one granted in scan order. With no grant, `rr` holds.
- **Output registers.** They load on every edge.
  - `regWrite` is set to the grant enables, or 0 if nothing is granted.
  - `wr`, `wd`, `wr2`, `wd2` and `wd15` load only for enabled ports; disabled ports hold their previous values.
- **Pending mask.** `pend_mask` is combinational. It is the OR of:
  - the destinations of valid holding registers, plus bit 15 when H_C is valid;
  - the addresses enabled in the current `regWrite`, plus bit 15 when `regWrite[2]` is set.
- **Reset.** On the reset edge:
  - all holding registers are invalidated and `rr` is set to A;
  - `regWrite`, `wr`, `wr2`, `wd`, `wd2` and `wd15` are set to 0;
  - after reset, `pend_mask` = 0 and every ready = 1.
  - A reset in mid-operation discards all buffered and unissued writes. A write already presented on `regWrite` at the reset edge is not re-issued.

## Timing
- **Latency.**
  - Accept at edge E.
  - Grant and output load at edge E+1: `regWrite` is visible in cycle E+1..E+2.
  - The register file captures the write at edge E+2.
- **Throughput.** One request per cycle per requester when it is not blocked, because ready stays high through a grant.
- **Deferral.** A requester that is not granted holds its request and keeps ready low until it is granted. It cannot starve: after any cycle in which it is eligible but loses, `rr` has advanced past the winners.
- **Simultaneous events.**
  - New accept and grant on the same edge: the holding register reloads with the new request.
  - Three valid requests, all eligible: two issue and one waits exactly one cycle.

## Test plan
- **Single request.** After reset, `alu_valid=1`, `alu_dest=1`, `alu_data=AAAA` for one cycle -> at the next edge `regWrite=001`, `wr=1`, `wd=AAAA`. One cycle later `regWrite=000`. `pend_mask` bit1 is high for 2 cycles.
- **Two independent requests.** ALU dest 2 `1111` and mem dest 3 `2222` in the same cycle, `rr=A` -> `regWrite=011` with `wr=2`/`wd=1111` and `wr2=3`/`wd2=2222`. Afterwards `rr=C`.
- **Destination collision.** ALU dest 5 `AAAA` and mem dest 5 `BBBB` together, `rr=A` -> cycle 1 issues `wr=5` with `AAAA` only and `mem_ready=0`. Cycle 2 issues `BBBB`. R5 ends at `BBBB`.
- **MDU with R15 conflict.** MDU dest 4, lo `0123`, hi `ABCD`, plus ALU dest 15 `5555`, `rr=C` -> `regWrite=101` with `wr=4`, `wd=0123`, `wd15=ABCD`. The ALU issues the next cycle with `wr=F`.
- **MDU to R15 and three-way contention.**
  - `mdu_dest=15` -> `regWrite=100` only, with `wd15=hi`.
  - All three requesters valid on distinct destinations (not 15) -> two are granted, the third issues the following cycle.
- **Reset mid-operation.** Hold all three requesters blocked, then assert `reset` for one edge -> at the next edge `regWrite=000`, `pend_mask=0000` and all readies are 1. No stale write issues afterwards.
